// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register in front of the MIPS ALU. Captures the decoded
// operands and control each cycle and presents them to the ALU. RAW hazards
// against the EX/MEM and MEM/WB producers are resolved by forwarding. A
// load-use hazard raises id_stall toward decode and inserts one bubble.
// Downstream hold freezes the stage; flush squashes the instruction it holds.
//
// Build option:
//   ALU_FORWARD_EN  defined   : MEM/WB forwarding; only load-use stalls.
//                   undefined : no forwarding; any RAW dependence on a valid
//                               EX, MEM or WB producer stalls decode.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   decode presents an instruction
//   id_rs_addr, id_rt_addr     source register numbers
//   id_rs_data, id_rt_data     register file read data
//   id_imm16, id_imm_sext      raw immediate, 1 = sign-extend
//   id_use_imm, id_sel         ALU B-operand select, ALU operation code
//   id_dest, id_reg_write      destination register and its write enable
//   id_mem_read                instruction is a load
//   mem_reg_write/dest/result  EX/MEM producer
//   wb_reg_write/dest/result   MEM/WB producer
//   hold, flush                downstream stall, branch squash
//   RSbus, RTbus               forwarded ALU operands
//   Imm, UseImm, SEL           extended immediate, B select, ALU op code
//   ex_valid, ex_dest,
//   ex_reg_write, ex_mem_read  control carried into EX/MEM
//   id_stall                   decode must hold its instruction this cycle
// -----------------------------------------------------------------------------
module alu_operand_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [15:0] id_imm16,
   input  logic        id_imm_sext,
   input  logic        id_use_imm,
   input  logic [7:0]  id_sel,
   input  logic [4:0]  id_dest,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_dest,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_dest,
   input  logic [31:0] wb_result,
   input  logic        hold,
   input  logic        flush,
   output logic [31:0] RSbus,
   output logic [31:0] RTbus,
   output logic [31:0] Imm,
   output logic        UseImm,
   output logic [7:0]  SEL,
   output logic        ex_valid,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        id_stall
);

   // Registered stage contents
   logic        r_ex_valid;
   logic [4:0]  r_rs_addr;
   logic [4:0]  r_rt_addr;
   logic [31:0] r_rs_val;
   logic [31:0] r_rt_val;
   logic [31:0] r_imm;
   logic        r_use_imm;
   logic [7:0]  r_sel;
   logic [4:0]  r_dest;
   logic        r_reg_write;
   logic        r_mem_read;

   logic [31:0] w_id_rs_val;   // decode operands after forwarding
   logic [31:0] w_id_rt_val;
   logic [31:0] w_imm_ext;
   logic        w_hazard;      // decode instruction must wait one cycle

   // True when the instruction in decode reads register `dest`. The rt field
   // is not a source when the immediate replaces the B operand. $0 never
   // creates a dependence.
   function automatic logic f_reads(input logic [4:0] dest,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       use_imm);
      return (dest != 5'd0) && ((dest == rs) || (!use_imm && (dest == rt)));
   endfunction

`ifdef ALU_FORWARD_EN
   // Operand select: newest producer (MEM) wins over WB, $0 is never bypassed.
   function automatic logic [31:0] f_fwd(input logic [4:0]  addr,
                                         input logic [31:0] regval,
                                         input logic        m_we,
                                         input logic [4:0]  m_dest,
                                         input logic [31:0] m_res,
                                         input logic        w_we,
                                         input logic [4:0]  w_dest,
                                         input logic [31:0] w_res);
      if (addr == 5'd0)
         return regval;
      if (m_we && (m_dest == addr))
         return m_res;
      if (w_we && (w_dest == addr))
         return w_res;
      return regval;
   endfunction

   // The capture path also catches a WB writer retiring in the same cycle
   // the register file was read.
   always_comb begin
      w_id_rs_val = f_fwd(id_rs_addr, id_rs_data, mem_reg_write, mem_dest,
                          mem_result, wb_reg_write, wb_dest, wb_result);
      w_id_rt_val = f_fwd(id_rt_addr, id_rt_data, mem_reg_write, mem_dest,
                          mem_result, wb_reg_write, wb_dest, wb_result);
      RSbus       = f_fwd(r_rs_addr, r_rs_val, mem_reg_write, mem_dest,
                          mem_result, wb_reg_write, wb_dest, wb_result);
      RTbus       = f_fwd(r_rt_addr, r_rt_val, mem_reg_write, mem_dest,
                          mem_result, wb_reg_write, wb_dest, wb_result);
   end

   // Only a load sitting in EX cannot be bypassed in time.
   assign w_hazard = id_valid && r_ex_valid && r_mem_read && r_reg_write &&
                     f_reads(r_dest, id_rs_addr, id_rt_addr, id_use_imm);
`else
   always_comb begin
      w_id_rs_val = id_rs_data;
      w_id_rt_val = id_rt_data;
      RSbus       = r_rs_val;
      RTbus       = r_rt_val;
   end

   // Without bypassing, decode waits until every in-flight writer of a
   // source register has retired past WB.
   assign w_hazard = id_valid &&
                     ((r_ex_valid && r_reg_write &&
                       f_reads(r_dest, id_rs_addr, id_rt_addr, id_use_imm)) ||
                      (mem_reg_write &&
                       f_reads(mem_dest, id_rs_addr, id_rt_addr, id_use_imm)) ||
                      (wb_reg_write &&
                       f_reads(wb_dest, id_rs_addr, id_rt_addr, id_use_imm)));

   // Producer results and stored source numbers only matter when bypassing.
   logic w_unused_fwd;
   assign w_unused_fwd = ^{mem_result, wb_result, r_rs_addr, r_rt_addr};
`endif

   assign w_imm_ext = {{16{id_imm_sext & id_imm16[15]}}, id_imm16};

   always_comb begin
      // NOTE: default assigned first so every path drives id_stall; a missed
      // branch in always_comb would otherwise infer a latch.
      id_stall = 1'b0;
      if (hold)
         id_stall = 1'b1;
      else if (w_hazard && !flush)
         id_stall = 1'b1;
   end

   // Priority: reset > flush > hold > bubble > capture.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (reset) begin
         r_ex_valid  <= 1'b0;
         r_rs_addr   <= 5'd0;
         r_rt_addr   <= 5'd0;
         r_rs_val    <= 32'd0;
         r_rt_val    <= 32'd0;
         r_imm       <= 32'd0;
         r_use_imm   <= 1'b0;
         r_sel       <= 8'h00;
         r_dest      <= 5'd0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (flush) begin
         // Control is cleared too so a squashed op never looks like a writer.
         r_ex_valid  <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (hold) begin
         // Keep refreshing the operands so a result retiring from WB during
         // the hold is not lost once the producer has left the pipeline.
         r_rs_val <= RSbus;
         r_rt_val <= RTbus;
      end else if (w_hazard) begin
         r_ex_valid  <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else begin
         r_ex_valid  <= id_valid;
         r_rs_addr   <= id_rs_addr;
         r_rt_addr   <= id_rt_addr;
         r_rs_val    <= w_id_rs_val;
         r_rt_val    <= w_id_rt_val;
         r_imm       <= w_imm_ext;
         r_use_imm   <= id_use_imm;
         r_sel       <= id_sel;
         r_dest      <= id_dest;
         r_reg_write <= id_valid && id_reg_write;
         r_mem_read  <= id_valid && id_mem_read;
      end
   end

   assign Imm          = r_imm;
   assign UseImm       = r_use_imm;
   assign SEL          = r_sel;
   assign ex_valid     = r_ex_valid;
   assign ex_dest      = r_dest;
   assign ex_reg_write = r_reg_write;
   assign ex_mem_read  = r_mem_read;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed scenarios followed by a random run. A behavioural model of the
// stage contents is advanced every clock from the operation rules and all
// outputs are compared against it on the falling edge; directed steps add
// explicit expected constants.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [15:0] id_imm16;
   logic        id_imm_sext;
   logic        id_use_imm;
   logic [7:0]  id_sel;
   logic [4:0]  id_dest;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        mem_reg_write;
   logic [4:0]  mem_dest;
   logic [31:0] mem_result;
   logic        wb_reg_write;
   logic [4:0]  wb_dest;
   logic [31:0] wb_result;
   logic        hold;
   logic        flush;
   logic [31:0] RSbus;
   logic [31:0] RTbus;
   logic [31:0] Imm;
   logic        UseImm;
   logic [7:0]  SEL;
   logic        ex_valid;
   logic [4:0]  ex_dest;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        id_stall;

   int total = 0;
   int bad   = 0;

`ifdef ALU_FORWARD_EN
   localparam logic [31:0] EXP_PRIO_MEM = 32'h11;
   localparam logic [31:0] EXP_PRIO_WB  = 32'h22;
   localparam logic [31:0] EXP_HOLD     = 32'hABCD;
`else
   localparam logic [31:0] EXP_PRIO_MEM = 32'h55;
   localparam logic [31:0] EXP_PRIO_WB  = 32'h55;
   localparam logic [31:0] EXP_HOLD     = 32'h1234;
`endif

   // What the stage holds; dc marks fields left undefined by a flush.
   typedef struct {
      logic        valid;
      logic [4:0]  rs_a;
      logic [4:0]  rt_a;
      logic [31:0] rs_v;
      logic [31:0] rt_v;
      logic [31:0] imm;
      logic        use_imm;
      logic [7:0]  sel;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
      bit          dc;
   } stage_t;

   stage_t m;

   alu_operand_stage dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_rs_addr    (id_rs_addr),
      .id_rt_addr    (id_rt_addr),
      .id_rs_data    (id_rs_data),
      .id_rt_data    (id_rt_data),
      .id_imm16      (id_imm16),
      .id_imm_sext   (id_imm_sext),
      .id_use_imm    (id_use_imm),
      .id_sel        (id_sel),
      .id_dest       (id_dest),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .mem_reg_write (mem_reg_write),
      .mem_dest      (mem_dest),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_dest       (wb_dest),
      .wb_result     (wb_result),
      .hold          (hold),
      .flush         (flush),
      .RSbus         (RSbus),
      .RTbus         (RTbus),
      .Imm           (Imm),
      .UseImm        (UseImm),
      .SEL           (SEL),
      .ex_valid      (ex_valid),
      .ex_dest       (ex_dest),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .id_stall      (id_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Value a source register should have right now.
   function automatic logic [31:0] mf(input logic [4:0] a, input logic [31:0] v);
      if (a == 5'd0)
         return v;
`ifdef ALU_FORWARD_EN
      if (mem_reg_write && mem_dest == a)
         return mem_result;
      if (wb_reg_write && wb_dest == a)
         return wb_result;
`endif
      return v;
   endfunction

   function automatic bit m_reads(input logic [4:0] d);
      return id_valid && d != 5'd0 &&
             (d == id_rs_addr || (!id_use_imm && d == id_rt_addr));
   endfunction

   function automatic bit m_stall();
      bit haz;
`ifdef ALU_FORWARD_EN
      haz = m.valid && m.mr && m.rw && m_reads(m.dest);
`else
      haz = (m.valid && m.rw && m_reads(m.dest)) ||
            (mem_reg_write && m_reads(mem_dest)) ||
            (wb_reg_write && m_reads(wb_dest));
`endif
      return hold || (haz && !flush);
   endfunction

   task automatic check_stage();
      check("ex_valid", 32'(ex_valid), 32'(m.valid));
      check("id_stall", 32'(id_stall), 32'(m_stall()));
      if (!m.dc) begin
         check("RSbus", RSbus, mf(m.rs_a, m.rs_v));
         check("RTbus", RTbus, mf(m.rt_a, m.rt_v));
         check("Imm", Imm, m.imm);
         check("UseImm", 32'(UseImm), 32'(m.use_imm));
         check("SEL", 32'(SEL), 32'(m.sel));
         check("ex_dest", 32'(ex_dest), 32'(m.dest));
         check("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
         check("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
      end
   endtask

   // Compare on the falling edge, then advance the model across the next
   // rising edge; returns 1 time unit after that edge.
   task automatic step();
      stage_t n;
      @(negedge clk);
      check_stage();
      n = m;
      if (reset) begin
         n = '{default: '0};
      end else if (flush) begin
         n.valid = 1'b0;
         n.dc    = 1'b1;
      end else if (hold) begin
         n.rs_v = mf(m.rs_a, m.rs_v);
         n.rt_v = mf(m.rt_a, m.rt_v);
      end else if (m_stall()) begin
         n.valid = 1'b0;
         n.rw    = 1'b0;
         n.mr    = 1'b0;
      end else begin
         n.valid   = id_valid;
         n.rs_a    = id_rs_addr;
         n.rt_a    = id_rt_addr;
         n.rs_v    = mf(id_rs_addr, id_rs_data);
         n.rt_v    = mf(id_rt_addr, id_rt_data);
         n.imm     = id_imm_sext ? 32'($signed(id_imm16)) : 32'(id_imm16);
         n.use_imm = id_use_imm;
         n.sel     = id_sel;
         n.dest    = id_dest;
         n.rw      = id_valid && id_reg_write;
         n.mr      = id_valid && id_mem_read;
         n.dc      = 1'b0;
      end
      @(posedge clk);
      m = n;
      #1;
   endtask

   task automatic idle();
      id_valid      = 1'b0;
      id_rs_addr    = 5'd0;
      id_rt_addr    = 5'd0;
      id_rs_data    = 32'd0;
      id_rt_data    = 32'd0;
      id_imm16      = 16'd0;
      id_imm_sext   = 1'b0;
      id_use_imm    = 1'b0;
      id_sel        = 8'h00;
      id_dest       = 5'd0;
      id_reg_write  = 1'b0;
      id_mem_read   = 1'b0;
      mem_reg_write = 1'b0;
      mem_dest      = 5'd0;
      mem_result    = 32'd0;
      wb_reg_write  = 1'b0;
      wb_dest       = 5'd0;
      wb_result     = 32'd0;
      hold          = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic set_decode(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [15:0] imm, input logic sext,
                             input logic use_imm, input logic [7:0] sel,
                             input logic [4:0] dest, input logic rw, input logic mr);
      id_valid     = v;
      id_rs_addr   = rs;
      id_rt_addr   = rt;
      id_rs_data   = rsd;
      id_rt_data   = rtd;
      id_imm16     = imm;
      id_imm_sext  = sext;
      id_use_imm   = use_imm;
      id_sel       = sel;
      id_dest      = dest;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   initial begin
      // Reset, then idle
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      m = '{default: '0};
      step();
      reset = 1'b0;
      step();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_RSbus", RSbus, 32'd0);
      check("rst_RTbus", RTbus, 32'd0);
      check("rst_Imm", Imm, 32'd0);
      check("rst_SEL", 32'(SEL), 32'd0);
      check("rst_id_stall", 32'(id_stall), 32'd0);

      // Immediate extension
      set_decode(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 16'h8004, 1'b1, 1'b1, 8'h21, 5'd9, 1'b1, 1'b0);
      step();
      check("imm_sext", Imm, 32'hFFFF8004);
      set_decode(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 16'h8004, 1'b0, 1'b1, 8'h21, 5'd9, 1'b1, 1'b0);
      step();
      check("imm_zext", Imm, 32'h00008004);

      // Forwarding priority and $0
      idle();
      set_decode(1'b1, 5'd5, 5'd6, 32'h55, 32'h66, 16'h0, 1'b0, 1'b0, 8'h03, 5'd10, 1'b0, 1'b0);
      step();
      id_valid      = 1'b0;
      mem_reg_write = 1'b1;
      mem_dest      = 5'd5;
      mem_result    = 32'h11;
      wb_reg_write  = 1'b1;
      wb_dest       = 5'd5;
      wb_result     = 32'h22;
      #1 check("fwd_mem_prio", RSbus, EXP_PRIO_MEM);
      mem_reg_write = 1'b0;
      #1 check("fwd_wb", RSbus, EXP_PRIO_WB);
      idle();
      set_decode(1'b1, 5'd0, 5'd0, 32'h77, 32'h88, 16'h0, 1'b0, 1'b0, 8'h04, 5'd11, 1'b0, 1'b0);
      step();
      id_valid      = 1'b0;
      mem_reg_write = 1'b1;
      mem_result    = 32'h11;
      wb_reg_write  = 1'b1;
      wb_result     = 32'h22;
      #1 check("zero_rs_no_fwd", RSbus, 32'h77);
      check("zero_rt_no_fwd", RTbus, 32'h88);
      step();

      // Load-use: lw $3 in EX, add uses $3
      idle();
      set_decode(1'b1, 5'd1, 5'd0, 32'h100, 32'h0, 16'h0010, 1'b1, 1'b1, 8'h23, 5'd3, 1'b1, 1'b1);
      step();
      set_decode(1'b1, 5'd3, 5'd4, 32'h0, 32'h44, 16'h0, 1'b0, 1'b0, 8'h20, 5'd6, 1'b1, 1'b0);
      #1 check("lu_stall", 32'(id_stall), 32'd1);
      step();
      check("lu_bubble", 32'(ex_valid), 32'd0);
      mem_reg_write = 1'b1;
      mem_dest      = 5'd3;
      mem_result    = 32'hBEEF;
`ifdef ALU_FORWARD_EN
      #1 check("lu_release", 32'(id_stall), 32'd0);
      step();
      check("lu_capture", 32'(ex_valid), 32'd1);
      id_valid      = 1'b0;
      mem_reg_write = 1'b0;
      wb_reg_write  = 1'b1;
      wb_dest       = 5'd3;
      wb_result     = 32'hBEEF;
      #1 check("lu_fwd", RSbus, 32'hBEEF);
`else
      #1 check("raw_mem_stall", 32'(id_stall), 32'd1);
      step();
      mem_reg_write = 1'b0;
      wb_reg_write  = 1'b1;
      wb_dest       = 5'd3;
      wb_result     = 32'hBEEF;
      #1 check("raw_wb_stall", 32'(id_stall), 32'd1);
      step();
      check("raw_bubble", 32'(ex_valid), 32'd0);
      wb_reg_write = 1'b0;
      id_rs_data   = 32'hBEEF;
      #1 check("raw_release", 32'(id_stall), 32'd0);
      step();
      check("raw_operand", RSbus, 32'hBEEF);
`endif
      step();

      // Hold for two cycles with a WB retire in the first
      idle();
      set_decode(1'b1, 5'd7, 5'd0, 32'h1234, 32'h0, 16'h0, 1'b0, 1'b1, 8'h5A, 5'd8, 1'b0, 1'b0);
      step();
      id_valid     = 1'b0;
      hold         = 1'b1;
      wb_reg_write = 1'b1;
      wb_dest      = 5'd7;
      wb_result    = 32'hABCD;
      #1 check("hold_stall_1", 32'(id_stall), 32'd1);
      step();
      wb_reg_write = 1'b0;
      #1 check("hold_stall_2", 32'(id_stall), 32'd1);
      check("hold_sel", 32'(SEL), 32'h5A);
      step();
      hold = 1'b0;
      #1 check("hold_rsbus", RSbus, EXP_HOLD);
      check("hold_sel_after", 32'(SEL), 32'h5A);
      step();

      // Flush together with hold and a load-use
      idle();
      set_decode(1'b1, 5'd1, 5'd0, 32'h100, 32'h0, 16'h0, 1'b1, 1'b1, 8'h23, 5'd3, 1'b1, 1'b1);
      step();
      set_decode(1'b1, 5'd3, 5'd4, 32'h0, 32'h44, 16'h0, 1'b0, 1'b0, 8'h20, 5'd6, 1'b1, 1'b0);
      hold  = 1'b1;
      flush = 1'b1;
      step();
      hold  = 1'b0;
      flush = 1'b0;
      #1 check("flush_valid", 32'(ex_valid), 32'd0);
      check("flush_stall", 32'(id_stall), 32'd0);
      step();

      // Reset in the middle of a hold
      idle();
      set_decode(1'b1, 5'd2, 5'd3, 32'h9, 32'hA, 16'h0, 1'b0, 1'b0, 8'h22, 5'd12, 1'b1, 1'b0);
      step();
      hold  = 1'b1;
      reset = 1'b1;
      step();
      reset    = 1'b0;
      hold     = 1'b0;
      id_valid = 1'b0;
      #1 check("rst_hold_valid", 32'(ex_valid), 32'd0);
      check("rst_hold_rw", 32'(ex_reg_write), 32'd0);
      step();

      // Random traffic on a small register window to provoke collisions
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 49) == 0);
         hold          = ($urandom_range(0, 7) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         id_rs_addr    = 5'($urandom_range(0, 3));
         id_rt_addr    = 5'($urandom_range(0, 3));
         id_rs_data    = $urandom;
         id_rt_data    = $urandom;
         id_imm16      = 16'($urandom);
         id_imm_sext   = 1'($urandom);
         id_use_imm    = 1'($urandom);
         id_sel        = 8'($urandom);
         id_dest       = 5'($urandom_range(0, 3));
         id_reg_write  = ($urandom_range(0, 3) != 0);
         id_mem_read   = 1'($urandom);
         mem_reg_write = 1'($urandom);
         mem_dest      = 5'($urandom_range(0, 3));
         mem_result    = $urandom;
         wb_reg_write  = 1'($urandom);
         wb_dest       = 5'($urandom_range(0, 3));
         wb_result     = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
